// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared constants for the multicycle MULT/DIV unit.
//   - FSM state encodings (3-bit) and the matching typed enum
//   - default operand width and iteration count
package mult_div_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned MD_ITER  = MD_WIDTH;

   localparam logic [2:0] ST_MD_IDLE    = 3'd0;
   localparam logic [2:0] ST_MD_MULT    = 3'd1;
   localparam logic [2:0] ST_MD_DIV     = 3'd2;
   localparam logic [2:0] ST_MD_DIV_FIX = 3'd3;
   localparam logic [2:0] ST_MD_DONE    = 3'd4;

   typedef enum logic [2:0] {
      StIdle   = ST_MD_IDLE,
      StMult   = ST_MD_MULT,
      StDiv    = ST_MD_DIV,
      StDivFix = ST_MD_DIV_FIX,
      StDone   = ST_MD_DONE
   } md_state_e;

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem_i     partial remainder (always < divisor_i)
//   quot_i    shifting dividend/quotient register; MSB is the next dividend bit
//   divisor_i divisor magnitude
//   rem_o     updated partial remainder
//   quot_o    quot_i shifted left with the new quotient bit in the LSB
module div_restore_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quot_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quot_o
);

   logic [WIDTH:0]   trial;
   // One extra bit so a full-range unsigned divisor can't alias the borrow.
   logic [WIDTH+1:0] diff;

   always_comb begin
      trial = {rem_i, quot_i[WIDTH-1]};
      diff  = {1'b0, trial} - {2'b00, divisor_i};
      if (diff[WIDTH+1]) begin
         // trial < divisor, so it fits in WIDTH bits
         rem_o  = trial[WIDTH-1:0];
         quot_o = {quot_i[WIDTH-2:0], 1'b0};
      end else begin
         rem_o  = diff[WIDTH-1:0];
         quot_o = {quot_i[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   start_mult          1-cycle strobe, signed A*B -> {HI,LO}
//   start_div           1-cycle strobe, signed A/B -> LO quotient, HI remainder
//   A, B                operands, captured on the strobe edge
//   HI, LO              result registers, held between operations
//   busy                high in MULT, DIV, DIV_FIX
//   done                1-cycle pulse, HI/LO already updated
//   div_zero            pulses with done when the divisor was zero (HI/LO untouched)
// Optional: define MULTDIV_EARLY_ZERO_EN to finish zero-operand operations in one step.
// done/div_zero are registered: DONE lasts two cycles, the second one carries the pulse,
// and strobes are ignored throughout.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH:0]   acc_q, acc_d;       // extra bit absorbs Booth add/sub overflow
   logic [WIDTH-1:0] q_q, q_d;           // multiplier, or dividend/quotient
   logic             q_m1_q, q_m1_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             neg_quot_q, neg_quot_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dz_pend_q, dz_pend_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;

   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quot;

   div_restore_step #(
      .WIDTH(WIDTH)
   ) u_div_step (
      .rem_i    (rem_q),
      .quot_i   (q_q),
      .divisor_i(dvsr_q),
      .rem_o    (step_rem),
      .quot_o   (step_quot)
   );

   always_comb begin
      m_ext = {mcand_q[WIDTH-1], mcand_q};
      unique case ({q_q[0], q_m1_q})
         2'b01:   booth_sum = acc_q + m_ext;
         2'b10:   booth_sum = acc_q - m_ext;
         default: booth_sum = acc_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      q_d        = q_q;
      q_m1_d     = q_m1_q;
      rem_d      = rem_q;
      dvsr_d     = dvsr_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      dz_pend_d  = dz_pend_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_mult) begin
`ifdef MULTDIV_EARLY_ZERO_EN
               if ((A == '0) || (B == '0)) begin
                  hi_d    = '0;
                  lo_d    = '0;
                  state_d = StDone;
               end else
`endif
               begin
                  mcand_d = A;
                  q_d     = B;
                  acc_d   = '0;
                  q_m1_d  = 1'b0;
                  cnt_d   = '0;
                  state_d = StMult;
               end
            end else if (start_div) begin
               if (B == '0) begin
                  dz_pend_d = 1'b1;
                  state_d   = StDone;
               end
`ifdef MULTDIV_EARLY_ZERO_EN
               else if (A == '0) begin
                  hi_d    = '0;
                  lo_d    = '0;
                  state_d = StDone;
               end
`endif
               else begin
                  q_d        = mag(A);
                  dvsr_d     = mag(B);
                  neg_quot_d = A[WIDTH-1] ^ B[WIDTH-1];
                  neg_rem_d  = A[WIDTH-1];
                  rem_d      = '0;
                  cnt_d      = '0;
                  state_d    = StDiv;
               end
            end
         end

         StMult: begin
            // Arithmetic shift right of {acc, Q, q_m1}
            acc_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_d    = {booth_sum[0], q_q[WIDTH-1:1]};
            q_m1_d = q_q[0];
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               hi_d    = acc_d[WIDTH-1:0];
               lo_d    = q_d;
               cnt_d   = '0;
               state_d = StDone;
            end
         end

         StDiv: begin
            rem_d = step_rem;
            q_d   = step_quot;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               cnt_d   = '0;
               state_d = StDivFix;
            end
         end

         StDivFix: begin
            lo_d    = neg_quot_q ? -q_q : q_q;
            hi_d    = neg_rem_q ? -rem_q : rem_q;
            state_d = StDone;
         end

         StDone: begin
            if (done_q) begin
               dz_pend_d = 1'b0;
               state_d   = StIdle;
            end else begin
               done_d     = 1'b1;
               div_zero_d = dz_pend_q;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         mcand_q    <= '0;
         acc_q      <= '0;
         q_q        <= '0;
         q_m1_q     <= 1'b0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         dz_pend_q  <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         q_q        <= q_d;
         q_m1_q     <= q_m1_d;
         rem_q      <= rem_d;
         dvsr_q     <= dvsr_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         dz_pend_q  <= dz_pend_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign HI       = hi_q;
   assign LO       = lo_q;
   assign busy     = (state_q == StMult) || (state_q == StDiv) || (state_q == StDivFix);
   assign done     = done_q;
   assign div_zero = div_zero_q;

endmodule
